// File: rtl/cmp_pkg.sv
// Shared definitions for the branch-condition unit: op codes, flag bit positions and the
// flag-vector type.
package cmp_pkg;

    localparam int unsigned FLAG_W = 8;

    localparam logic [3:0] CMP_OP_EQ  = 4'd0;
    localparam logic [3:0] CMP_OP_NE  = 4'd1;
    localparam logic [3:0] CMP_OP_LEZ = 4'd2;
    localparam logic [3:0] CMP_OP_LTZ = 4'd3;
    localparam logic [3:0] CMP_OP_GEZ = 4'd4;
    localparam logic [3:0] CMP_OP_GTZ = 4'd5;
    localparam logic [3:0] CMP_OP_LT  = 4'd6;
    localparam logic [3:0] CMP_OP_LTU = 4'd7;

    localparam int unsigned FLAG_EQ  = 0;
    localparam int unsigned FLAG_NEQ = 1;
    localparam int unsigned FLAG_LEZ = 2;
    localparam int unsigned FLAG_LTZ = 3;
    localparam int unsigned FLAG_GEZ = 4;
    localparam int unsigned FLAG_GTZ = 5;
    localparam int unsigned FLAG_LT  = 6;
    localparam int unsigned FLAG_LTU = 7;

    typedef logic [FLAG_W-1:0] cmp_flags_t;

    // Codes 8..15 have the top bit set and are all reserved.
    function automatic logic cmp_op_reserved(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational branch-condition evaluation: all eight flags of (rs, rt) plus the
// condition selected by op and a reserved-op indication.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic [3:0]       op_i,
    input  logic [Width-1:0] rs_i,
    input  logic [Width-1:0] rt_i,
    output cmp_flags_t       flags_o,
    output logic             taken_o,
    output logic             ill_o
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs_i == '0);
    assign rs_neg  = rs_i[Width-1];

    always_comb begin
        flags_o           = '0;
        flags_o[FLAG_EQ]  = (rs_i == rt_i);
        flags_o[FLAG_NEQ] = (rs_i != rt_i);
        flags_o[FLAG_LEZ] = rs_neg | rs_zero;
        flags_o[FLAG_LTZ] = rs_neg;
        flags_o[FLAG_GEZ] = ~rs_neg;
        flags_o[FLAG_GTZ] = ~rs_neg & ~rs_zero;
        flags_o[FLAG_LT]  = ($signed(rs_i) < $signed(rt_i));
        flags_o[FLAG_LTU] = (rs_i < rt_i);
    end

    always_comb begin
        ill_o   = cmp_op_reserved(op_i);
        taken_o = 1'b0;
        unique case (op_i)
            CMP_OP_EQ:  taken_o = flags_o[FLAG_EQ];
            CMP_OP_NE:  taken_o = flags_o[FLAG_NEQ];
            CMP_OP_LEZ: taken_o = flags_o[FLAG_LEZ];
            CMP_OP_LTZ: taken_o = flags_o[FLAG_LTZ];
            CMP_OP_GEZ: taken_o = flags_o[FLAG_GEZ];
            CMP_OP_GTZ: taken_o = flags_o[FLAG_GTZ];
            CMP_OP_LT:  taken_o = flags_o[FLAG_LT];
            CMP_OP_LTU: taken_o = flags_o[FLAG_LTU];
            default:    taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined branch-condition unit: evaluates at the input, carries the result through
// Stages valid/ready slots, and counts accepted taken results with a saturating counter.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned Width  = 32,
    parameter int unsigned Stages = 2,
    parameter int unsigned TagW   = 5,
    parameter int unsigned CntW   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        in_op_i,
    input  logic [Width-1:0]  in_rs_i,
    input  logic [Width-1:0]  in_rt_i,
    input  logic [TagW-1:0]   in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_taken_o,
    output logic [FLAG_W-1:0] out_flags_o,
    output logic              out_ill_o,
    output logic [TagW-1:0]   out_tag_o,
    input  logic              cnt_clr_i,
    output logic [CntW-1:0]   taken_cnt_o
);

    // Slot payload layout: {flags, taken, ill, tag}.
    localparam int unsigned PayW = FLAG_W + 2 + TagW;

    cmp_flags_t core_flags;
    logic       core_taken;
    logic       core_ill;

    cmp_core #(
        .Width (Width)
    ) u_core (
        .op_i    (in_op_i),
        .rs_i    (in_rs_i),
        .rt_i    (in_rt_i),
        .flags_o (core_flags),
        .taken_o (core_taken),
        .ill_o   (core_ill)
    );

    logic [Stages-1:0] slot_valid;
    logic [Stages-1:0] slot_ready;
    logic [PayW-1:0]   slot_pay [Stages];

    for (genvar k = 0; k < Stages; k++) begin : g_slot
        logic            valid_q;
        logic [PayW-1:0] pay_q;
        logic            up_valid;
        logic [PayW-1:0] up_pay;

        if (k == 0) begin : g_head
            assign up_valid = in_valid_i & in_ready_o;
            assign up_pay   = {core_flags, core_taken, core_ill, in_tag_i};
        end else begin : g_body
            assign up_valid = slot_valid[k-1];
            assign up_pay   = slot_pay[k-1];
        end

        // A slot can move when any later slot has a hole or the consumer takes the head.
        if (k == Stages - 1) begin : g_tail
            assign slot_ready[k] = out_ready_i;
        end else begin : g_inner
            assign slot_ready[k] = out_ready_i | ~(&slot_valid[Stages-1:k+1]);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                pay_q   <= '0;
            end else begin
                if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (slot_ready[k]) begin
                    valid_q <= up_valid;
                end
                if (slot_ready[k] && up_valid) begin
                    pay_q <= up_pay;
                end
            end
        end

        assign slot_valid[k] = valid_q;
        assign slot_pay[k]   = pay_q;
    end

    assign in_ready_o  = slot_ready[0] & ~flush_i;
    assign out_valid_o = slot_valid[Stages-1] & ~flush_i;
    assign {out_flags_o, out_taken_o, out_ill_o, out_tag_o} = slot_pay[Stages-1];

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (out_valid_o && out_ready_i && out_taken_o && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign taken_cnt_o = cnt_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe: scoreboard of modelled results checked on every output transfer,
// plus per-scenario tasks for latency, back-pressure, flush, counter and reset.
module tb_cmp_pipe;

    localparam int unsigned Width  = 32;
    localparam int unsigned Stages = 2;
    localparam int unsigned TagW   = 5;
    localparam int unsigned CntW   = 2;

    typedef struct packed {
        logic [7:0]      flags;
        logic            taken;
        logic            ill;
        logic [TagW-1:0] tag;
    } res_t;

    logic             clk_i;
    logic             rst_ni;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       in_op_i;
    logic [Width-1:0] in_rs_i;
    logic [Width-1:0] in_rt_i;
    logic [TagW-1:0]  in_tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_taken_o;
    logic [7:0]       out_flags_o;
    logic             out_ill_o;
    logic [TagW-1:0]  out_tag_o;
    logic             cnt_clr_i;
    logic [CntW-1:0]  taken_cnt_o;

    int              checks;
    int              errors;
    int              n_out;
    res_t            exp_q[$];
    logic [CntW-1:0] model_cnt;
    logic            stall_prev;
    res_t            last_out;

    cmp_pipe #(
        .Width  (Width),
        .Stages (Stages),
        .TagW   (TagW),
        .CntW   (CntW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_op_i     (in_op_i),
        .in_rs_i     (in_rs_i),
        .in_rt_i     (in_rt_i),
        .in_tag_i    (in_tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_taken_o (out_taken_o),
        .out_flags_o (out_flags_o),
        .out_ill_o   (out_ill_o),
        .out_tag_o   (out_tag_o),
        .cnt_clr_i   (cnt_clr_i),
        .taken_cnt_o (taken_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic res_t model(input logic [3:0] op, input logic [Width-1:0] rs,
                                   input logic [Width-1:0] rt, input logic [TagW-1:0] tag);
        res_t r;
        r.flags[0] = (rs == rt);
        r.flags[1] = (rs != rt);
        r.flags[2] = ($signed(rs) <= 0);
        r.flags[3] = ($signed(rs) < 0);
        r.flags[4] = ($signed(rs) >= 0);
        r.flags[5] = ($signed(rs) > 0);
        r.flags[6] = ($signed(rs) < $signed(rt));
        r.flags[7] = (rs < rt);
        r.ill      = (op > 4'd7);
        case (op)
            4'd0:    r.taken = (rs == rt);
            4'd1:    r.taken = (rs != rt);
            4'd2:    r.taken = ($signed(rs) <= 0);
            4'd3:    r.taken = ($signed(rs) < 0);
            4'd4:    r.taken = ($signed(rs) >= 0);
            4'd5:    r.taken = ($signed(rs) > 0);
            4'd6:    r.taken = ($signed(rs) < $signed(rt));
            4'd7:    r.taken = (rs < rt);
            default: r.taken = 1'b0;
        endcase
        r.tag = tag;
        return r;
    endfunction

    function automatic logic [Width-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard, counter model and stall-stability monitor; inputs settle before this edge.
    always @(negedge clk_i) begin
        res_t got;
        res_t want;
        logic xfer_taken;
        if (rst_ni) begin
            got = {out_flags_o, out_taken_o, out_ill_o, out_tag_o};
            xfer_taken = 1'b0;
            checks++;
            if (taken_cnt_o !== model_cnt) begin
                errors++;
                $display("FAIL taken_cnt got %0d want %0d at %0t", taken_cnt_o, model_cnt, $time);
            end
            if (stall_prev && out_valid_o) begin
                checks++;
                if (got !== last_out) begin
                    errors++;
                    $display("FAIL stall_stable got %h want %h at %0t", got, last_out, $time);
                end
            end
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result got %h want none (unexpected) at %0t", got, $time);
                end else begin
                    want = exp_q.pop_front();
                    xfer_taken = want.taken;
                    n_out++;
                    if (got !== want) begin
                        errors++;
                        $display("FAIL result got %h want %h at %0t", got, want, $time);
                    end
                end
            end
            if (cnt_clr_i) model_cnt = '0;
            else if (xfer_taken && model_cnt != {CntW{1'b1}}) model_cnt = model_cnt + 1'b1;
            if (flush_i) exp_q.delete();
            if (in_valid_i && in_ready_o)
                exp_q.push_back(model(in_op_i, in_rs_i, in_rt_i, in_tag_i));
            stall_prev = out_valid_o && !out_ready_i && !flush_i;
            last_out = got;
        end
    end

    task automatic drive(input logic [3:0] op, input logic [Width-1:0] rs,
                         input logic [Width-1:0] rt, input logic [TagW-1:0] tag);
        in_valid_i = 1'b1;
        in_op_i    = op;
        in_rs_i    = rs;
        in_rt_i    = rt;
        in_tag_i   = tag;
    endtask

    task automatic drain();
        int cyc = 0;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
    endtask

    // Accepts two taken EQ ops while the consumer is stalled, leaving both slots full.
    task automatic fill_two(input logic [TagW-1:0] base);
        int acc = 0;
        int cyc = 0;
        out_ready_i = 1'b0;
        while (acc < 2 && cyc < 20) begin
            @(posedge clk_i); #1;
            drive(4'd0, 32'h55, 32'h55, base + TagW'(acc));
            @(negedge clk_i);
            if (in_ready_o) acc++;
            cyc++;
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL fill_accepts got %0d want 2", acc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks += 6;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid_o); end
        if (out_taken_o !== 1'b0) begin errors++; $display("FAIL rst_taken got %b want 0", out_taken_o); end
        if (out_flags_o !== 8'h00) begin errors++; $display("FAIL rst_flags got %h want 00", out_flags_o); end
        if (out_ill_o !== 1'b0) begin errors++; $display("FAIL rst_ill got %b want 0", out_ill_o); end
        if (out_tag_o !== '0) begin errors++; $display("FAIL rst_tag got %h want 0", out_tag_o); end
        if (taken_cnt_o !== '0) begin errors++; $display("FAIL rst_cnt got %0d want 0", taken_cnt_o); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready_o); end
    endtask

    task automatic test_basic();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        drive(4'd0, 32'h1234, 32'h1234, 5'd3);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        for (int i = 1; i <= int'(Stages); i++) begin
            @(negedge clk_i);
            checks++;
            if (out_valid_o !== (i == int'(Stages))) begin
                errors++;
                $display("FAIL latency cycle %0d got %b want %b", i, out_valid_o, i == int'(Stages));
            end
            if (i < int'(Stages)) begin @(posedge clk_i); #1; end
        end
        checks += 3;
        if (out_taken_o !== 1'b1) begin errors++; $display("FAIL eq_taken got %b want 1", out_taken_o); end
        if (out_flags_o !== 8'h31) begin errors++; $display("FAIL eq_flags got %h want 31", out_flags_o); end
        if (out_tag_o !== 5'd3) begin errors++; $display("FAIL eq_tag got %h want 3", out_tag_o); end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (taken_cnt_o !== 2'd1) begin errors++; $display("FAIL eq_cnt got %0d want 1", taken_cnt_o); end
    endtask

    task automatic test_conditions();
        logic [3:0]       ops  [3] = '{4'd6, 4'd7, 4'd5};
        logic [Width-1:0] rss  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [Width-1:0] rts  [3] = '{32'h1, 32'h1, 32'h0};
        logic             tkn  [3] = '{1'b1, 1'b0, 1'b0};
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            drive(ops[i], rss[i], rts[i], TagW'(i + 8));
            repeat (Stages) begin @(posedge clk_i); #1; in_valid_i = 1'b0; end
            @(negedge clk_i);
            checks++;
            if (out_taken_o !== tkn[i]) begin
                errors++;
                $display("FAIL cond%0d_taken got %b want %b", i, out_taken_o, tkn[i]);
            end
            if (i == 1) begin
                checks++;
                if (out_flags_o[7:6] !== 2'b01) begin
                    errors++;
                    $display("FAIL ltu_flags got %b want 01", out_flags_o[7:6]);
                end
            end
            if (i == 2) begin
                checks++;
                if (out_flags_o[3] !== 1'b1) begin
                    errors++;
                    $display("FAIL gtz_ltz got %b want 1", out_flags_o[3]);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            logic [Width-1:0] a;
            @(posedge clk_i); #1;
            a = pick();
            out_ready_i = ($urandom_range(0, 3) != 0);
            drive(4'($urandom_range(0, 15)), a, ($urandom_range(0, 3) == 0) ? a : pick(),
                  TagW'(i));
            @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        drain();
    endtask

    task automatic test_back_to_back();
        int t = 0;
        int cyc = 0;
        int start = n_out;
        while ((t < 10 || exp_q.size() != 0) && cyc < 60) begin
            @(posedge clk_i); #1;
            out_ready_i = !(cyc >= 3 && cyc <= 6);
            if (t < 10) drive(4'(t % 8), Width'(t), 32'h4, TagW'(t));
            else in_valid_i = 1'b0;
            @(negedge clk_i);
            if (cyc >= 3 && cyc <= 6) begin
                checks++;
                if (in_ready_o !== 1'b0 || t != 3) begin
                    errors++;
                    $display("FAIL b2b_stall cyc %0d got ready=%b accepts=%0d want ready=0 accepts=3",
                             cyc, in_ready_o, t);
                end
            end
            if (in_valid_i && in_ready_o) t++;
            cyc++;
        end
        in_valid_i = 1'b0;
        checks++;
        if (t != 10 || n_out - start != 10) begin
            errors++;
            $display("FAIL b2b_count got in=%0d out=%0d want 10/10", t, n_out - start);
        end
    endtask

    task automatic test_flush();
        logic [CntW-1:0] saved;
        fill_two(5'd12);
        drive(4'd0, 32'h1, 32'h1, 5'd30);
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        saved = taken_cnt_o;
        checks += 2;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid_o); end
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready_o); end
        @(posedge clk_i); #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        checks += 2;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after got %b want 0", out_valid_o); end
        if (taken_cnt_o !== saved) begin
            errors++;
            $display("FAIL flush_cnt got %0d want %0d", taken_cnt_o, saved);
        end
    endtask

    task automatic test_counter();
        logic [CntW-1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        cnt_clr_i = 1'b1;
        @(posedge clk_i); #1;
        cnt_clr_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (taken_cnt_o !== 2'd0) begin errors++; $display("FAIL cnt_clr got %0d want 0", taken_cnt_o); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            drive(4'd1, 32'h1, 32'h2, TagW'(i));
            repeat (Stages + 1) begin @(posedge clk_i); #1; in_valid_i = 1'b0; end
            @(negedge clk_i);
            checks++;
            if (taken_cnt_o !== exp_cnt[i]) begin
                errors++;
                $display("FAIL cnt_step%0d got %0d want %0d", i, taken_cnt_o, exp_cnt[i]);
            end
        end
        @(posedge clk_i); #1;
        drive(4'd0, 32'h9, 32'h9, 5'd17);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        cnt_clr_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (!(out_valid_o === 1'b1 && out_taken_o === 1'b1)) begin
            errors++;
            $display("FAIL clr_xfer got v=%b t=%b want v=1 t=1", out_valid_o, out_taken_o);
        end
        @(posedge clk_i); #1;
        cnt_clr_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (taken_cnt_o !== 2'd0) begin errors++; $display("FAIL clr_prio got %0d want 0", taken_cnt_o); end
        @(posedge clk_i); #1;
        drive(4'd9, 32'h5, 32'h5, 5'd7);
        repeat (Stages) begin @(posedge clk_i); #1; in_valid_i = 1'b0; end
        @(negedge clk_i);
        checks += 2;
        if (out_ill_o !== 1'b1 || out_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL ill got ill=%b taken=%b want ill=1 taken=0", out_ill_o, out_taken_o);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        if (taken_cnt_o !== 2'd0) begin errors++; $display("FAIL ill_cnt got %0d want 0", taken_cnt_o); end
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        drive(4'd0, 32'h2, 32'h2, 5'd20);
        repeat (Stages + 1) begin @(posedge clk_i); #1; in_valid_i = 1'b0; end
        fill_two(5'd21);
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        exp_q.delete();
        model_cnt  = '0;
        stall_prev = 1'b0;
        #1;
        checks += 5;
        if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", out_valid_o); end
        if (out_taken_o !== 1'b0) begin errors++; $display("FAIL mid_taken got %b want 0", out_taken_o); end
        if (out_flags_o !== 8'h00) begin errors++; $display("FAIL mid_flags got %h want 00", out_flags_o); end
        if (out_tag_o !== '0) begin errors++; $display("FAIL mid_tag got %h want 0", out_tag_o); end
        if (taken_cnt_o !== '0) begin errors++; $display("FAIL mid_cnt got %0d want 0", taken_cnt_o); end
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", in_ready_o); end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        drive(4'd4, 32'h10, 32'h0, 5'd25);
        @(negedge clk_i);
        for (int i = 1; i <= int'(Stages); i++) begin
            @(posedge clk_i); #1;
            in_valid_i = 1'b0;
            @(negedge clk_i);
            checks++;
            if (out_valid_o !== (i == int'(Stages))) begin
                errors++;
                $display("FAIL mid_latency cycle %0d got %b want %b", i, out_valid_o,
                         i == int'(Stages));
            end
        end
        drain();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        n_out       = 0;
        model_cnt   = '0;
        stall_prev  = 1'b0;
        last_out    = '0;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_op_i     = '0;
        in_rs_i     = '0;
        in_rt_i     = '0;
        in_tag_i    = '0;
        out_ready_i = 1'b0;
        cnt_clr_i   = 1'b0;
        test_reset();
        test_basic();
        test_conditions();
        test_back_to_back();
        test_flush();
        test_counter();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
